// File: rtl/rename_map.sv
// rename_map: two-wide rename stage (RAT, S1 allocation wait, output register).
// Define RENAME_PERF_EN to add the saturating stall_cycles counter output.
module rename_map (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  dec_valid,
    input  logic [1:0]  dec_wr_en,
    input  logic [9:0]  dec_rd,
    input  logic [9:0]  dec_rn,
    input  logic [9:0]  dec_rm,
    output logic        dec_ready,
    output logic [1:0]  alloc_en,
    input  logic [11:0] alloc_phys,
    input  logic [1:0]  alloc_valid,
    output logic [1:0]  ren_valid,
    output logic [1:0]  ren_wr_en,
    output logic [11:0] ren_prd,
    output logic [11:0] ren_prn,
    output logic [11:0] ren_prm,
    output logic [11:0] ren_old_prd,
    input  logic        ren_ready
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 48;
    localparam int WIDTH     = 2;
    localparam int TAG_W     = $clog2(PHYS_REGS);
    localparam int AREG_W    = $clog2(ARCH_REGS);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [AREG_W-1:0] areg_t;

    localparam areg_t XZR     = areg_t'(ARCH_REGS - 1);
    localparam tag_t  XZR_TAG = tag_t'(ARCH_REGS - 1);

    // Unpacked views of the per-slot input fields
    areg_t            in_rd   [WIDTH];
    areg_t            in_rn   [WIDTH];
    areg_t            in_rm   [WIDTH];
    tag_t             in_phys [WIDTH];
    logic [WIDTH-1:0] need_in;

    always_comb begin
        for (int s = 0; s < WIDTH; s++) begin
            in_rd[s]   = dec_rd[s*AREG_W +: AREG_W];
            in_rn[s]   = dec_rn[s*AREG_W +: AREG_W];
            in_rm[s]   = dec_rm[s*AREG_W +: AREG_W];
            in_phys[s] = alloc_phys[s*TAG_W +: TAG_W];
            need_in[s] = dec_valid[s] && dec_wr_en[s]
                         && (in_rd[s] != XZR);
        end
    end

    // S1 holding register
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_v_q,     s1_v_d;
    logic [WIDTH-1:0] s1_need_q,  s1_need_d;
    logic [WIDTH-1:0] s1_got_q,   s1_got_d;
    areg_t            s1_rd_q   [WIDTH];
    areg_t            s1_rd_d   [WIDTH];
    areg_t            s1_rn_q   [WIDTH];
    areg_t            s1_rn_d   [WIDTH];
    areg_t            s1_rm_q   [WIDTH];
    areg_t            s1_rm_d   [WIDTH];
    tag_t             s1_phys_q [WIDTH];
    tag_t             s1_phys_d [WIDTH];

    tag_t             rat_q [ARCH_REGS];
    tag_t             rat_d [ARCH_REGS];

    // Output register
    logic [WIDTH-1:0] ren_valid_q, ren_valid_d;
    logic [WIDTH-1:0] ren_wr_en_q, ren_wr_en_d;
    tag_t             ren_prd_q [WIDTH];
    tag_t             ren_prd_d [WIDTH];
    tag_t             ren_prn_q [WIDTH];
    tag_t             ren_prn_d [WIDTH];
    tag_t             ren_prm_q [WIDTH];
    tag_t             ren_prm_d [WIDTH];
    tag_t             ren_old_q [WIDTH];
    tag_t             ren_old_d [WIDTH];

    logic [WIDTH-1:0] have;
    logic             out_free;
    logic             s1_done;
    logic             accept;
    tag_t             new_tag [WIDTH];
    tag_t             src_n   [WIDTH];
    tag_t             src_m   [WIDTH];
    tag_t             old_tag [WIDTH];

    always_comb begin
        for (int s = 0; s < WIDTH; s++) begin
            have[s] = !s1_need_q[s] || s1_got_q[s]
                      || alloc_valid[s];
        end
        out_free  = (ren_valid_q == '0) || ren_ready;
        s1_done   = s1_valid_q && (&have) && out_free;
        dec_ready = !s1_valid_q || s1_done;
        accept    = (dec_valid != '0) && dec_ready;
    end

    // A retry only happens while S1 cannot complete, so it never
    // overlaps the request of a newly accepted group.
    always_comb begin
        alloc_en = '0;
        if (accept) begin
            alloc_en = need_in;
        end else if (s1_valid_q) begin
            alloc_en = s1_need_q & ~s1_got_q & ~alloc_valid;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_v_d     = s1_v_q;
        s1_need_d  = s1_need_q;
        s1_got_d   = s1_got_q;
        s1_rd_d    = s1_rd_q;
        s1_rn_d    = s1_rn_q;
        s1_rm_d    = s1_rm_q;
        s1_phys_d  = s1_phys_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_v_d     = dec_valid;
            s1_need_d  = need_in;
            s1_got_d   = '0;
            s1_rd_d    = in_rd;
            s1_rn_d    = in_rn;
            s1_rm_d    = in_rm;
        end else if (s1_done) begin
            s1_valid_d = 1'b0;
            s1_got_d   = '0;
        end else if (s1_valid_q) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (s1_need_q[s] && !s1_got_q[s]
                    && alloc_valid[s]) begin
                    s1_got_d[s]  = 1'b1;
                    s1_phys_d[s] = in_phys[s];
                end
            end
        end
    end

    // Table lookups plus slot-0 -> slot-1 bypass
    always_comb begin
        for (int s = 0; s < WIDTH; s++) begin
            new_tag[s] = s1_got_q[s] ? s1_phys_q[s] : in_phys[s];
            src_n[s]   = (s1_rn_q[s] == XZR) ? XZR_TAG
                                             : rat_q[s1_rn_q[s]];
            src_m[s]   = (s1_rm_q[s] == XZR) ? XZR_TAG
                                             : rat_q[s1_rm_q[s]];
            old_tag[s] = rat_q[s1_rd_q[s]];
        end
        if (s1_need_q[0]) begin
            if (s1_rn_q[1] == s1_rd_q[0]) begin
                src_n[1] = new_tag[0];
            end
            if (s1_rm_q[1] == s1_rd_q[0]) begin
                src_m[1] = new_tag[0];
            end
            if (s1_rd_q[1] == s1_rd_q[0]) begin
                old_tag[1] = new_tag[0];
            end
        end
    end

    always_comb begin
        rat_d = rat_q;
        if (s1_done) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (s1_need_q[s]) begin
                    rat_d[s1_rd_q[s]] = new_tag[s];
                end
            end
        end
    end

    always_comb begin
        ren_valid_d = ren_valid_q;
        ren_wr_en_d = ren_wr_en_q;
        ren_prd_d   = ren_prd_q;
        ren_prn_d   = ren_prn_q;
        ren_prm_d   = ren_prm_q;
        ren_old_d   = ren_old_q;
        if (s1_done) begin
            for (int s = 0; s < WIDTH; s++) begin
                ren_valid_d[s] = s1_v_q[s];
                ren_wr_en_d[s] = s1_need_q[s];
                ren_prd_d[s]   = s1_need_q[s] ? new_tag[s] : '0;
                ren_old_d[s]   = s1_need_q[s] ? old_tag[s] : '0;
                ren_prn_d[s]   = s1_v_q[s] ? src_n[s] : '0;
                ren_prm_d[s]   = s1_v_q[s] ? src_m[s] : '0;
            end
        end else if (ren_ready) begin
            ren_valid_d = '0;
            ren_wr_en_d = '0;
            for (int s = 0; s < WIDTH; s++) begin
                ren_prd_d[s] = '0;
                ren_prn_d[s] = '0;
                ren_prm_d[s] = '0;
                ren_old_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_v_q      <= '0;
            s1_need_q   <= '0;
            s1_got_q    <= '0;
            ren_valid_q <= '0;
            ren_wr_en_q <= '0;
            for (int s = 0; s < WIDTH; s++) begin
                s1_rd_q[s]   <= '0;
                s1_rn_q[s]   <= '0;
                s1_rm_q[s]   <= '0;
                s1_phys_q[s] <= '0;
                ren_prd_q[s] <= '0;
                ren_prn_q[s] <= '0;
                ren_prm_q[s] <= '0;
                ren_old_q[s] <= '0;
            end
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= tag_t'(i);
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_v_q      <= s1_v_d;
            s1_need_q   <= s1_need_d;
            s1_got_q    <= s1_got_d;
            s1_rd_q     <= s1_rd_d;
            s1_rn_q     <= s1_rn_d;
            s1_rm_q     <= s1_rm_d;
            s1_phys_q   <= s1_phys_d;
            rat_q       <= rat_d;
            ren_valid_q <= ren_valid_d;
            ren_wr_en_q <= ren_wr_en_d;
            ren_prd_q   <= ren_prd_d;
            ren_prn_q   <= ren_prn_d;
            ren_prm_q   <= ren_prm_d;
            ren_old_q   <= ren_old_d;
        end
    end

    always_comb begin
        ren_valid = ren_valid_q;
        ren_wr_en = ren_wr_en_q;
        for (int s = 0; s < WIDTH; s++) begin
            ren_prd[s*TAG_W +: TAG_W]     = ren_prd_q[s];
            ren_prn[s*TAG_W +: TAG_W]     = ren_prn_q[s];
            ren_prm[s*TAG_W +: TAG_W]     = ren_prm_q[s];
            ren_old_prd[s*TAG_W +: TAG_W] = ren_old_q[s];
        end
    end

`ifdef RENAME_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (s1_valid_q && !s1_done && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
